// File: rtl/rv_plic_pkg.sv
// Shared types and helpers for the PLIC claim/complete controller.
//   gw_state_e : per-source gateway state
//   src_id_w() : source ID width for a given source count (ID 0 reserved for "none")
//   src_id_t   : source ID type for the default 32-source configuration
package rv_plic_pkg;

    localparam int unsigned N_SOURCE_DEF = 32;
    localparam int unsigned ID_NONE      = 0;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    // Width of a source ID: IDs run 1..n, plus 0 meaning "none".
    function automatic int unsigned src_id_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned SRCW_DEF = $clog2(N_SOURCE_DEF + 1);

    typedef logic [SRCW_DEF-1:0] src_id_t;

endpackage

// File: rtl/rv_plic_gateway.sv
// Per-source interrupt gateway: turns a raw level/edge source into a pending bit and
// holds it off until the owning target completes.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   src           raw source line (already synchronized)
//   le            1 = edge-triggered, 0 = level-triggered
//   claim_hit     a claim for this source was granted this cycle
//   complete_hit  some target wrote this source ID to its complete register
//   ip            pending bit (registered), high only in GW_PENDING
module rv_plic_gateway
    import rv_plic_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic src,
    input  logic le,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic ip
);

    gw_state_e state_q, state_d;
    logic      edge_prev_q;
    logic      edge_seen_q, edge_seen_d;
    logic      ip_q;
    logic      rise;

    assign rise = src & ~edge_prev_q;
    assign ip   = ip_q;

    // State, edge history and pending flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= GW_IDLE;
            edge_prev_q <= 1'b0;
            edge_seen_q <= 1'b0;
            ip_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_prev_q <= src;
            edge_seen_q <= edge_seen_d;
            ip_q        <= (state_d == GW_PENDING);
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        edge_seen_d = edge_seen_q;
        case (state_q)
            GW_IDLE: begin
                if (le ? rise : src) state_d = GW_PENDING;
            end
            GW_PENDING: begin
                // Further edges are absorbed into the single pending bit.
                if (claim_hit) state_d = GW_CLAIMED;
            end
            GW_CLAIMED: begin
                if (complete_hit) begin
                    // An edge remembered during service (or arriving with the complete)
                    // re-pends directly; level sources re-pend via IDLE.
                    state_d     = (edge_seen_q || (le && rise)) ? GW_PENDING : GW_IDLE;
                    edge_seen_d = 1'b0;
                end else if (le && rise) begin
                    edge_seen_d = 1'b1;
                end
            end
            default: begin
                state_d     = GW_IDLE;
                edge_seen_d = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_plic_claim_ctrl.sv
// PLIC gateway array plus claim/complete sequencer.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   intr_src_i, le_i raw sources and their trigger mode
//   ip_o             pending bits to every target selector
//   tgt_irq_id_i     per-target current best ID (SRCW bits each)
//   claim_re_i       per-target claim read strobe
//   claim_rvalid_o   per-target claim response valid (1 cycle after the strobe)
//   claim_id_o       per-target claimed ID, held until the next strobe
//   complete_we_i    per-target complete write strobe
//   complete_id_i    per-target completed ID
module rv_plic_claim_ctrl
    import rv_plic_pkg::*;
#(
    parameter int unsigned N_SOURCE = 32,
    parameter int unsigned N_TARGET = 2,
    parameter int unsigned SRCW     = src_id_w(N_SOURCE)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_SOURCE-1:0]      intr_src_i,
    input  logic [N_SOURCE-1:0]      le_i,
    output logic [N_SOURCE-1:0]      ip_o,
    input  logic [N_TARGET*SRCW-1:0] tgt_irq_id_i,
    input  logic [N_TARGET-1:0]      claim_re_i,
    output logic [N_TARGET-1:0]      claim_rvalid_o,
    output logic [N_TARGET*SRCW-1:0] claim_id_o,
    input  logic [N_TARGET-1:0]      complete_we_i,
    input  logic [N_TARGET*SRCW-1:0] complete_id_i
);

    logic [SRCW-1:0]          tid [N_TARGET];
    logic [SRCW-1:0]          cid [N_TARGET];
    logic [N_TARGET-1:0]      pend;
    logic [N_TARGET-1:0]      grant;
    logic [N_SOURCE-1:0]      claim_hit;
    logic [N_SOURCE-1:0]      cmp_hit;
    logic [N_TARGET-1:0]      rvalid_q;
    logic [N_TARGET*SRCW-1:0] claim_id_q;

    assign claim_rvalid_o = rvalid_q;
    assign claim_id_o     = claim_id_q;

    // Claim arbitration: fixed priority by target index among requesters of the same ID.
    // Pending lookup matches only IDs 1..N_SOURCE, so 0 and out-of-range IDs never grant.
    always_comb begin
        pend  = '0;
        grant = '0;
        for (int t = 0; t < int'(N_TARGET); t++) begin
            tid[t] = tgt_irq_id_i[t*SRCW +: SRCW];
            cid[t] = complete_id_i[t*SRCW +: SRCW];
        end
        for (int t = 0; t < int'(N_TARGET); t++) begin
            for (int s = 0; s < int'(N_SOURCE); s++) begin
                if (tid[t] == SRCW'(s + 1)) pend[t] = ip_o[s];
            end
            grant[t] = claim_re_i[t] & pend[t];
            for (int u = 0; u < t; u++) begin
                if (claim_re_i[u] && (tid[u] == tid[t])) grant[t] = 1'b0;
            end
        end
    end

    // Per-source decode of granted claims and of completes (OR over targets)
    always_comb begin
        claim_hit = '0;
        cmp_hit   = '0;
        for (int s = 0; s < int'(N_SOURCE); s++) begin
            for (int t = 0; t < int'(N_TARGET); t++) begin
                if (grant[t] && (tid[t] == SRCW'(s + 1)))         claim_hit[s] = 1'b1;
                if (complete_we_i[t] && (cid[t] == SRCW'(s + 1))) cmp_hit[s]   = 1'b1;
            end
        end
    end

    // Claim response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q   <= '0;
            claim_id_q <= '0;
        end else begin
            rvalid_q <= claim_re_i;
            for (int t = 0; t < int'(N_TARGET); t++) begin
                if (claim_re_i[t]) begin
                    claim_id_q[t*SRCW +: SRCW] <= grant[t] ? tid[t] : SRCW'(ID_NONE);
                end
            end
        end
    end

    for (genvar s = 0; s < int'(N_SOURCE); s++) begin : g_gw
        rv_plic_gateway u_gw (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .src          (intr_src_i[s]),
            .le           (le_i[s]),
            .claim_hit    (claim_hit[s]),
            .complete_hit (cmp_hit[s]),
            .ip           (ip_o[s])
        );
    end

endmodule
